// File: rtl/coin_collector.sv
// Coin collector front-end: accumulates credit, latches product/quantity and
// issues a one-cycle purchase strobe or refund pulse to the vending machine.
module coin_collector #(
    parameter int TIMEOUT_CYCLES = 1000,
    parameter int MAX_CREDIT     = 15
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       coin_valid,
    input  logic [1:0] coin_value,
    input  logic [2:0] product_sel,
    input  logic [3:0] qty_sel,
    input  logic       confirm,
    input  logic       cancel,
    output logic       costumer_mode,
    output logic [3:0] costumer_money,
    output logic [2:0] product,
    output logic [3:0] quantitiy,
    output logic       coin_reject,
    output logic       refund_valid,
    output logic [3:0] refund_amount,
    output logic [3:0] credit,
    output logic       busy
);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_COLLECT = 2'd1,
        ST_VEND    = 2'd2,
        ST_REFUND  = 2'd3
    } state_t;

    localparam int CW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CW-1:0] CNT_LAST  = CW'(TIMEOUT_CYCLES - 1);
    localparam logic [4:0]    MAX_C     = 5'(MAX_CREDIT);

    function automatic logic [4:0] coin_decode(input logic [1:0] code);
        logic [4:0] v;
        case (code)
            2'b00:   v = 5'd1;
            2'b01:   v = 5'd2;
            2'b10:   v = 5'd5;
            2'b11:   v = 5'd10;
            default: v = 5'd0;
        endcase
        return v;
    endfunction

    state_t        state_q, state_d;
    logic [3:0]    credit_q, credit_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [2:0]    prod_q, prod_d;
    logic [3:0]    qty_q, qty_d;
    logic          mode_q, mode_d;
    logic [3:0]    money_q, money_d;
    logic          reject_q, reject_d;
    logic          refund_valid_q, refund_valid_d;
    logic [3:0]    refund_amt_q, refund_amt_d;
    logic          busy_q, busy_d;

    logic [4:0]    sum_s;
    logic          accept_s;
    logic          activity_s;

    assign sum_s      = {1'b0, credit_q} + coin_decode(coin_value);
    assign accept_s   = (sum_s <= MAX_C);
    assign activity_s = coin_valid | confirm | cancel;

    // Next-state, credit, timeout and registered-output computation
    always_comb begin
        state_d  = state_q;
        credit_d = credit_q;
        cnt_d    = cnt_q;
        prod_d   = prod_q;
        qty_d    = qty_q;
        reject_d = 1'b0;

        case (state_q)
            ST_IDLE: begin
                cnt_d = '0;
                if (coin_valid) begin
                    if (accept_s) begin
                        state_d  = ST_COLLECT;
                        credit_d = sum_s[3:0];
                    end else begin
                        reject_d = 1'b1;
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_COLLECT: begin
                prod_d = product_sel;
                qty_d  = qty_sel;
                cnt_d  = activity_s ? '0 : cnt_q + CW'(1);
                // Cancel and a taken confirm both swallow a same-cycle coin
                if (cancel) begin
                    state_d  = ST_REFUND;
                    reject_d = coin_valid;
                    cnt_d    = '0;
                end else if (confirm && (credit_q != 4'd0) && (qty_sel != 4'd0)) begin
                    state_d  = ST_VEND;
                    reject_d = coin_valid;
                    cnt_d    = '0;
                end else if (coin_valid) begin
                    if (accept_s) begin
                        credit_d = sum_s[3:0];
                    end else begin
                        reject_d = 1'b1;
                    end
                end else if (cnt_q == CNT_LAST) begin
                    state_d = ST_REFUND;
                    cnt_d   = '0;
                end else begin
                    state_d = ST_COLLECT;
                end
            end
            ST_VEND, ST_REFUND: begin
                state_d  = ST_IDLE;
                credit_d = 4'd0;
                cnt_d    = '0;
                reject_d = coin_valid;
            end
            default: begin
                state_d  = ST_IDLE;
                credit_d = 4'd0;
                cnt_d    = '0;
            end
        endcase

        mode_d         = (state_d == ST_VEND);
        money_d        = mode_d ? credit_d : 4'd0;
        refund_valid_d = (state_d == ST_REFUND);
        refund_amt_d   = refund_valid_d ? credit_d : 4'd0;
        busy_d         = mode_d | refund_valid_d;
    end

    // State and output registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= ST_IDLE;
            credit_q       <= 4'd0;
            cnt_q          <= '0;
            prod_q         <= 3'd0;
            qty_q          <= 4'd0;
            mode_q         <= 1'b0;
            money_q        <= 4'd0;
            reject_q       <= 1'b0;
            refund_valid_q <= 1'b0;
            refund_amt_q   <= 4'd0;
            busy_q         <= 1'b0;
        end else begin
            state_q        <= state_d;
            credit_q       <= credit_d;
            cnt_q          <= cnt_d;
            prod_q         <= prod_d;
            qty_q          <= qty_d;
            mode_q         <= mode_d;
            money_q        <= money_d;
            reject_q       <= reject_d;
            refund_valid_q <= refund_valid_d;
            refund_amt_q   <= refund_amt_d;
            busy_q         <= busy_d;
        end
    end

    assign costumer_mode  = mode_q;
    assign costumer_money = money_q;
    assign product        = prod_q;
    assign quantitiy      = qty_q;
    assign coin_reject    = reject_q;
    assign refund_valid   = refund_valid_q;
    assign refund_amount  = refund_amt_q;
    assign credit         = credit_q;
    assign busy           = busy_q;

endmodule

// File: tb/tb_coin_collector.sv
// Directed scoreboard bench for coin_collector (TIMEOUT_CYCLES = 8).
module tb_coin_collector;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       coin_valid;
    logic [1:0] coin_value;
    logic [2:0] product_sel;
    logic [3:0] qty_sel;
    logic       confirm;
    logic       cancel;
    logic       costumer_mode;
    logic [3:0] costumer_money;
    logic [2:0] product;
    logic [3:0] quantitiy;
    logic       coin_reject;
    logic       refund_valid;
    logic [3:0] refund_amount;
    logic [3:0] credit;
    logic       busy;

    coin_collector #(.TIMEOUT_CYCLES(8), .MAX_CREDIT(15)) dut (
        .clk(clk), .rst_n(rst_n), .coin_valid(coin_valid), .coin_value(coin_value),
        .product_sel(product_sel), .qty_sel(qty_sel), .confirm(confirm), .cancel(cancel),
        .costumer_mode(costumer_mode), .costumer_money(costumer_money), .product(product),
        .quantitiy(quantitiy), .coin_reject(coin_reject), .refund_valid(refund_valid),
        .refund_amount(refund_amount), .credit(credit), .busy(busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0] money;
        logic [2:0] prod;
        logic [3:0] qty;
    } vend_t;

    vend_t      vend_exp[$];
    logic [3:0] refund_exp[$];
    int n_cmp = 0;
    int n_err = 0;
    int rej_exp = 0;
    int rej_seen = 0;

    localparam logic [1:0] C1 = 2'b00, C2 = 2'b01, C5 = 2'b10, C10 = 2'b11;

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp_v);
        n_cmp++;
        assert (obs === exp_v) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
        end
    endtask

    task automatic monitor();
        vend_t      v;
        logic [3:0] r;
        if (costumer_mode === 1'b1) begin
            if (vend_exp.size() == 0) begin
                chk("unexpected_vend", {7'd0, costumer_mode}, 8'd0);
            end else begin
                v = vend_exp.pop_front();
                chk("vend_money", {4'd0, costumer_money}, {4'd0, v.money});
                chk("vend_product", {5'd0, product}, {5'd0, v.prod});
                chk("vend_qty", {4'd0, quantitiy}, {4'd0, v.qty});
                chk("vend_busy", {7'd0, busy}, 8'd1);
            end
        end
        if (refund_valid === 1'b1) begin
            if (refund_exp.size() == 0) begin
                chk("unexpected_refund", {7'd0, refund_valid}, 8'd0);
            end else begin
                r = refund_exp.pop_front();
                chk("refund_amount", {4'd0, refund_amount}, {4'd0, r});
                chk("refund_busy", {7'd0, busy}, 8'd1);
            end
        end
        if (coin_reject === 1'b1) rej_seen++;
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
        monitor();
    endtask

    task automatic drive(input logic cv, input logic [1:0] val, input logic cf,
                         input logic cn, input logic [2:0] ps, input logic [3:0] qs);
        coin_valid  = cv;
        coin_value  = val;
        confirm     = cf;
        cancel      = cn;
        product_sel = ps;
        qty_sel     = qs;
        tick();
        coin_valid = 1'b0;
        confirm    = 1'b0;
        cancel     = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0; coin_valid = 1'b0; coin_value = 2'b00; product_sel = 3'd0;
        qty_sel = 4'd0; confirm = 1'b0; cancel = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_mode", {7'd0, costumer_mode}, 8'd0);
        chk("rst_credit", {4'd0, credit}, 8'd0);
        chk("rst_refund", {7'd0, refund_valid}, 8'd0);
        chk("rst_busy", {7'd0, busy}, 8'd0);
        chk("rst_product", {5'd0, product}, 8'd0);
        rst_n = 1'b1;

        // Coins 5,2,1 then confirm product 3 qty 2
        drive(1'b1, C5, 1'b0, 1'b0, 3'd0, 4'd0);
        chk("t1_credit5", {4'd0, credit}, 8'd5);
        drive(1'b1, C2, 1'b0, 1'b0, 3'd0, 4'd0);
        chk("t1_credit7", {4'd0, credit}, 8'd7);
        drive(1'b1, C1, 1'b0, 1'b0, 3'd0, 4'd0);
        chk("t1_credit8", {4'd0, credit}, 8'd8);
        vend_exp.push_back('{money: 4'd8, prod: 3'd3, qty: 4'd2});
        drive(1'b0, C1, 1'b1, 1'b0, 3'd3, 4'd2);
        chk("t1_vend_queue", 8'(vend_exp.size()), 8'd0);
        rej_exp++;
        drive(1'b1, C5, 1'b0, 1'b0, 3'd3, 4'd2);
        chk("t1_mode_low", {7'd0, costumer_mode}, 8'd0);
        chk("t1_credit_clr", {4'd0, credit}, 8'd0);
        chk("t1_product_hold", {5'd0, product}, 8'd3);
        chk("t1_qty_hold", {4'd0, quantitiy}, 8'd2);
        chk("t1_busy_low", {7'd0, busy}, 8'd0);
        chk("t1_busy_reject", 8'(rej_seen), 8'(rej_exp));

        // Over-limit coin then cancel
        drive(1'b1, C10, 1'b0, 1'b0, 3'd0, 4'd0);
        drive(1'b1, C5, 1'b0, 1'b0, 3'd0, 4'd0);
        chk("t2_credit15", {4'd0, credit}, 8'd15);
        rej_exp++;
        drive(1'b1, C1, 1'b0, 1'b0, 3'd0, 4'd0);
        chk("t2_credit_hold", {4'd0, credit}, 8'd15);
        chk("t2_reject", 8'(rej_seen), 8'(rej_exp));
        refund_exp.push_back(4'd15);
        drive(1'b0, C1, 1'b0, 1'b1, 3'd0, 4'd0);
        chk("t2_refund_queue", 8'(refund_exp.size()), 8'd0);
        tick();
        chk("t2_credit_clr", {4'd0, credit}, 8'd0);

        // Inactivity timeout
        drive(1'b1, C2, 1'b0, 1'b0, 3'd0, 4'd0);
        refund_exp.push_back(4'd2);
        repeat (7) tick();
        chk("t3_no_early_refund", {7'd0, refund_valid}, 8'd0);
        chk("t3_credit_hold", {4'd0, credit}, 8'd2);
        tick();
        chk("t3_refund_queue", 8'(refund_exp.size()), 8'd0);
        tick();

        // Confirm and cancel together -> refund wins
        drive(1'b1, C5, 1'b0, 1'b0, 3'd0, 4'd0);
        refund_exp.push_back(4'd5);
        drive(1'b0, C1, 1'b1, 1'b1, 3'd1, 4'd1);
        chk("t4_refund_queue", 8'(refund_exp.size()), 8'd0);
        tick();

        // Confirm and coin together -> coin rejected, vend with old credit
        drive(1'b1, C5, 1'b0, 1'b0, 3'd0, 4'd0);
        vend_exp.push_back('{money: 4'd5, prod: 3'd5, qty: 4'd1});
        rej_exp++;
        drive(1'b1, C2, 1'b1, 1'b0, 3'd5, 4'd1);
        tick();
        chk("t5_vend_queue", 8'(vend_exp.size()), 8'd0);
        chk("t5_reject", 8'(rej_seen), 8'(rej_exp));
        chk("t5_credit_clr", {4'd0, credit}, 8'd0);

        // Confirm with qty 0 is ignored
        drive(1'b1, C5, 1'b0, 1'b0, 3'd0, 4'd0);
        drive(1'b0, C1, 1'b1, 1'b0, 3'd2, 4'd0);
        chk("t6_no_vend", {7'd0, costumer_mode}, 8'd0);
        chk("t6_busy", {7'd0, busy}, 8'd0);
        chk("t6_credit", {4'd0, credit}, 8'd5);
        refund_exp.push_back(4'd5);
        drive(1'b0, C1, 1'b0, 1'b1, 3'd2, 4'd0);
        tick();

        // Reset during VEND
        drive(1'b1, C5, 1'b0, 1'b0, 3'd0, 4'd0);
        confirm = 1'b1; product_sel = 3'd6; qty_sel = 4'd3;
        @(posedge clk);
        #2;
        confirm = 1'b0;
        chk("t7_in_vend", {7'd0, costumer_mode}, 8'd1);
        chk("t7_money", {4'd0, costumer_money}, 8'd5);
        rst_n = 1'b0;
        #1;
        chk("t7_rst_mode", {7'd0, costumer_mode}, 8'd0);
        chk("t7_rst_money", {4'd0, costumer_money}, 8'd0);
        chk("t7_rst_product", {5'd0, product}, 8'd0);
        chk("t7_rst_qty", {4'd0, quantitiy}, 8'd0);
        chk("t7_rst_credit", {4'd0, credit}, 8'd0);
        chk("t7_rst_busy", {7'd0, busy}, 8'd0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        chk("t7_post_credit", {4'd0, credit}, 8'd0);
        chk("t7_post_mode", {7'd0, costumer_mode}, 8'd0);

        chk("final_vend_queue", 8'(vend_exp.size()), 8'd0);
        chk("final_refund_queue", 8'(refund_exp.size()), 8'd0);
        chk("final_rejects", 8'(rej_seen), 8'(rej_exp));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
